// File: rtl/ram_loader.sv
// Synchronous byte-stream boot loader: parses a framed image, writes it into RAM
// and holds the CPU core in reset until a complete, checksum-valid frame arrives.
module ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter bit CHECKSUM   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  core_reset,
  output logic                  loading,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);
  localparam int         ABYTES = ADDR_WIDTH / 8;
  localparam int         WBYTES = DATA_WIDTH / 8;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] A_LAST = 8'(ABYTES - 1);
  localparam logic [7:0] W_LAST = 8'(WBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e                  state_q, state_d, tail;
  logic [7:0]              bcnt_q, bcnt_d;
  logic [15:0]             count_q, count_d;
  logic [7:0]              sum_q, sum_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic [15:0]             words_q, words_d;
  logic                    in_ready_q, in_ready_d;
  logic                    ram_we_q, ram_we_d;
  logic                    core_reset_q, core_reset_d;
  logic                    loading_q, loading_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    xfer;

  assign xfer = in_valid && in_ready_q;
  // After the last word (or an empty frame) either the checksum byte or completion follows.
  assign tail = CHECKSUM ? S_CHECK : S_DONE;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    count_d     = count_q;
    sum_d       = sum_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    words_d     = words_q;
    if (xfer && (state_q inside {S_ADDR, S_COUNT, S_DATA, S_CHECK}))
      sum_d = sum_q + in_data;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (xfer && in_data == SYNC) begin
          state_d = S_ADDR;
          bcnt_d  = 8'd0;
          sum_d   = 8'd0;
          words_d = 16'd0;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          ram_addr_d = (ram_addr_q << 8) | ADDR_WIDTH'(in_data);
          bcnt_d     = bcnt_q + 8'd1;
          if (bcnt_q == A_LAST) begin
            bcnt_d  = 8'd0;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (xfer) begin
          count_d = {count_q[7:0], in_data};
          bcnt_d  = bcnt_q + 8'd1;
          if (bcnt_q == 8'd1) begin
            bcnt_d  = 8'd0;
            state_d = (count_d != 16'd0) ? S_DATA : tail;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          ram_wdata_d = (ram_wdata_q << 8) | DATA_WIDTH'(in_data);
          bcnt_d      = bcnt_q + 8'd1;
          if (bcnt_q == W_LAST) begin
            bcnt_d  = 8'd0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
        words_d    = words_q + 16'd1;
        state_d    = (words_d == count_q) ? tail : S_DATA;
      end
      S_CHECK: begin
        if (xfer) state_d = (sum_d == 8'd0) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d   = (state_d != S_WRITE);
    ram_we_d     = (state_d == S_WRITE);
    core_reset_d = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    loading_d    = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      count_q      <= '0;
      sum_q        <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      words_q      <= '0;
      in_ready_q   <= 1'b1;
      ram_we_q     <= 1'b0;
      core_reset_q <= 1'b1;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      words_q      <= words_d;
      in_ready_q   <= in_ready_d;
      ram_we_q     <= ram_we_d;
      core_reset_q <= core_reset_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // A reset arriving while in WRITE must suppress that cycle's strobe.
  assign ram_we       = ram_we_q && !reset;
  assign in_ready     = in_ready_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign core_reset   = core_reset_q;
  assign loading      = loading_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
endmodule
